demod_mac_scheduler: RTL and testbench

DEMOD_MAC_SCHEDULER -- requirements
Module: demod_mac_scheduler

---
 rtl/demod_pkg.sv | 17 +
 rtl/demod_mac_q16.sv | 24 ++
 rtl/demod_mac_scheduler.sv | 92 +++++++++
 tb/tb_demod_mac_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared Q16.16 constants and FSM encoding for the demodulation
// multiply-accumulate scheduler.
package demod_pkg;

  localparam int Q_WIDTH = 32;

  localparam logic [Q_WIDTH-1:0] REF_POS_DEFAULT = 32'h0001_0000;
  localparam logic [Q_WIDTH-1:0] REF_NEG_DEFAULT = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/demod_mac_q16.sv
// Combinational Q16.16 multiply-accumulate: acc + ((sample * ref) >>> 16),
// wrapping modulo 2^32.
module demod_mac_q16
  import demod_pkg::*;
(
  input  logic [Q_WIDTH-1:0] acc,
  input  logic [Q_WIDTH-1:0] sample,
  input  logic [Q_WIDTH-1:0] ref_val,
  output logic [Q_WIDTH-1:0] acc_next
);

  logic signed [2*Q_WIDTH-1:0] sample_ext;
  logic signed [2*Q_WIDTH-1:0] ref_ext;
  logic signed [2*Q_WIDTH-1:0] product;

  // Both operands are sign-extended to 64 bits, so the low 64 bits of the
  // product are the exact signed product.
  assign sample_ext = {{Q_WIDTH{sample[Q_WIDTH-1]}}, sample};
  assign ref_ext    = {{Q_WIDTH{ref_val[Q_WIDTH-1]}}, ref_val};
  assign product    = sample_ext * ref_ext;

  assign acc_next = acc + Q_WIDTH'(product >>> 16);

endmodule

// File: rtl/demod_mac_scheduler.sv
// Accumulates NSEG Q16.16 segments against an alternating +/-1.0 reference
// and publishes the signed sum plus a sign decision once per symbol.
module demod_mac_scheduler
  import demod_pkg::*;
#(
  parameter int                 NSEG    = 10,
  parameter logic [Q_WIDTH-1:0] REF_POS = REF_POS_DEFAULT,
  parameter logic [Q_WIDTH-1:0] REF_NEG = REF_NEG_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [Q_WIDTH-1:0] seg_data,
  input  logic               seg_valid,
  output logic               seg_ready,
  output logic [3:0]         seg_idx,
  output logic               busy,
  output logic [Q_WIDTH-1:0] acc_out,
  output logic               bit_out,
  output logic               done
);

  localparam logic [3:0] LAST_IDX = 4'(NSEG - 1);

  state_t             state;
  logic [Q_WIDTH-1:0] acc;
  logic [Q_WIDTH-1:0] acc_next;
  logic [Q_WIDTH-1:0] ref_sel;
  logic               decision;
  logic               accept;
  logic               last_seg;

  assign seg_ready = (state == ST_ACCUM);
  assign busy      = (state != ST_IDLE);
  assign accept    = seg_valid && seg_ready;
  assign last_seg  = (seg_idx == LAST_IDX);
  assign ref_sel   = seg_idx[0] ? REF_NEG : REF_POS;

  demod_mac_q16 u_mac (
    .acc      (acc),
    .sample   (seg_data),
    .ref_val  (ref_sel),
    .acc_next (acc_next)
  );

  // DECIDE latches the sign decision; DONE publishes sum, decision and the
  // done pulse together so consumers see a coherent result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      acc      <= '0;
      seg_idx  <= '0;
      acc_out  <= '0;
      bit_out  <= 1'b0;
      decision <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc     <= '0;
            seg_idx <= '0;
            state   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            if (last_seg) begin
              state <= ST_DECIDE;
            end else begin
              seg_idx <= seg_idx + 4'd1;
            end
          end
        end
        ST_DECIDE: begin
          decision <= ($signed(acc) > 32'sd0);
          state    <= ST_DONE;
        end
        ST_DONE: begin
          acc_out <= acc;
          bit_out <= decision;
          done    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_mac_scheduler.sv
// Scoreboard bench for demod_mac_scheduler: expected symbol results are
// queued when driven and compared against each observed done pulse.
module tb_demod_mac_scheduler;

  localparam int NSEG = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] seg_data;
  logic        seg_valid;
  logic        seg_ready;
  logic [3:0]  seg_idx;
  logic        busy;
  logic [31:0] acc_out;
  logic        bit_out;
  logic        done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [31:0] segs [NSEG];
  logic [31:0] exp_acc_q [$];
  logic        exp_bit_q [$];
  logic [31:0] obs_acc_q [$];
  logic        obs_bit_q [$];
  logic        obs_busy_q [$];
  int          obs_cyc_q [$];

  demod_mac_scheduler #(.NSEG(NSEG)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seg_data  (seg_data),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .seg_idx   (seg_idx),
    .busy      (busy),
    .acc_out   (acc_out),
    .bit_out   (bit_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      obs_acc_q.push_back(acc_out);
      obs_bit_q.push_back(bit_out);
      obs_busy_q.push_back(busy);
      obs_cyc_q.push_back(cyc);
    end
  end

  // With +1.0/-1.0 references each product is just +seg or -seg.
  function automatic logic [31:0] model_sum();
    logic [31:0] a;
    a = 32'h0;
    for (int i = 0; i < NSEG; i++) begin
      if (i % 2 == 0) a = a + segs[i];
      else            a = a - segs[i];
    end
    return a;
  endfunction

  task automatic send_symbol(input int gaps, input bit hold_start, output int start_cyc);
    int gap_at [NSEG];
    int guard;
    logic [31:0] m;
    for (int i = 0; i < NSEG; i++) gap_at[i] = 0;
    for (int g = 0; g < gaps; g++) gap_at[$urandom_range(NSEG - 1, 1)]++;
    m = model_sum();
    exp_acc_q.push_back(m);
    exp_bit_q.push_back($signed(m) > 0);
    start = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!seg_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    start_cyc = cyc;
    if (!hold_start) start = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      for (int g = 0; g < gap_at[i]; g++) begin
        seg_valid = 1'b0;
        @(negedge clk);
      end
      seg_valid = 1'b1;
      seg_data  = segs[i];
      guard = 0;
      while (!seg_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
    end
    seg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    seg_valid = 1'b0;
    seg_data = 32'h0;
    #2;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (seg_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", seg_ready); else passed++;
    total++; if (seg_idx !== 4'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", seg_idx); else passed++;
    total++; if (acc_out !== 32'h0) $display("[TB] FAIL reset_acc: got %h expected 00000000", acc_out); else passed++;
    total++; if (bit_out !== 1'b0) $display("[TB] FAIL reset_bit: got %b expected 0", bit_out); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("[TB] FAIL idle_wait: busy got %b expected 0", busy); else passed++;
  endtask

  task automatic test_basic();
    int s, guard;
    logic [31:0] ea;
    logic eb;
    for (int i = 0; i < NSEG; i++) segs[i] = 32'h0001_0000;
    send_symbol(0, 1'b0, s);
    guard = 0;
    while (obs_acc_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
    total++;
    if (obs_acc_q.size() == 0) $display("[TB] FAIL basic_done: got no done expected one pulse");
    else begin
      passed++;
      ea = exp_acc_q.pop_front();
      eb = exp_bit_q.pop_front();
      total++; if (obs_acc_q[0] !== ea) $display("[TB] FAIL basic_acc: got %h expected %h", obs_acc_q[0], ea); else passed++;
      total++; if (obs_acc_q[0] !== 32'h0) $display("[TB] FAIL basic_acc_const: got %h expected 00000000", obs_acc_q[0]); else passed++;
      total++; if (obs_bit_q[0] !== eb) $display("[TB] FAIL basic_bit: got %b expected %b", obs_bit_q[0], eb); else passed++;
      total++; if (obs_cyc_q[0] - s !== 12) $display("[TB] FAIL basic_latency: got %0d expected 12", obs_cyc_q[0] - s); else passed++;
      void'(obs_acc_q.pop_front()); void'(obs_bit_q.pop_front());
      void'(obs_busy_q.pop_front()); void'(obs_cyc_q.pop_front());
    end
    repeat (4) @(negedge clk);
    total++; if (obs_acc_q.size() != 0) $display("[TB] FAIL basic_single_done: got %0d extra expected 0", obs_acc_q.size()); else passed++;
    total++; if (seg_idx !== 4'(NSEG - 1)) $display("[TB] FAIL basic_idx_hold: got %0d expected %0d", seg_idx, NSEG - 1); else passed++;
  endtask

  task automatic test_alternating(input int gaps, input int exp_latency);
    int s, guard;
    logic [31:0] ea;
    logic eb;
    for (int i = 0; i < NSEG; i++) segs[i] = (i % 2 == 0) ? 32'h0001_0000 : 32'hFFFF_0000;
    send_symbol(gaps, 1'b0, s);
    guard = 0;
    while (obs_acc_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
    total++;
    if (obs_acc_q.size() == 0) $display("[TB] FAIL alt_done: got no done expected one pulse (gaps %0d)", gaps);
    else begin
      passed++;
      ea = exp_acc_q.pop_front();
      eb = exp_bit_q.pop_front();
      total++; if (obs_acc_q[0] !== ea) $display("[TB] FAIL alt_acc: got %h expected %h", obs_acc_q[0], ea); else passed++;
      total++; if (obs_acc_q[0] !== 32'h000A_0000) $display("[TB] FAIL alt_acc_const: got %h expected 000a0000", obs_acc_q[0]); else passed++;
      total++; if (obs_bit_q[0] !== eb) $display("[TB] FAIL alt_bit: got %b expected %b", obs_bit_q[0], eb); else passed++;
      total++; if (obs_cyc_q[0] - s !== exp_latency) $display("[TB] FAIL alt_latency: got %0d expected %0d", obs_cyc_q[0] - s, exp_latency); else passed++;
      void'(obs_acc_q.pop_front()); void'(obs_bit_q.pop_front());
      void'(obs_busy_q.pop_front()); void'(obs_cyc_q.pop_front());
    end
    repeat (5) @(negedge clk);
    total++; if (acc_out !== 32'h000A_0000) $display("[TB] FAIL alt_hold: got %h expected 000a0000", acc_out); else passed++;
  endtask

  task automatic test_reset_midway();
    int s, guard;
    logic [31:0] ea;
    for (int i = 0; i < NSEG; i++) segs[i] = 32'h0001_0000;
    start = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!seg_ready && guard < 50) begin @(negedge clk); guard++; end
    start = 1'b0;
    seg_valid = 1'b1;
    seg_data = 32'h0001_0000;
    repeat (5) @(negedge clk);
    seg_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if (acc_out !== 32'h0) $display("[TB] FAIL mid_reset_acc: got %h expected 00000000", acc_out); else passed++;
    total++; if (seg_idx !== 4'd0) $display("[TB] FAIL mid_reset_idx: got %0d expected 0", seg_idx); else passed++;
    total++; if (busy !== 1'b0 || seg_ready !== 1'b0) $display("[TB] FAIL mid_reset_state: got busy %b ready %b expected 0 0", busy, seg_ready); else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (obs_acc_q.size() != 0) $display("[TB] FAIL mid_no_done: got %0d done expected 0", obs_acc_q.size()); else passed++;
    send_symbol(0, 1'b0, s);
    guard = 0;
    while (obs_acc_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
    repeat (4) @(negedge clk);
    total++;
    if (obs_acc_q.size() != 1) $display("[TB] FAIL mid_fresh_count: got %0d done expected 1", obs_acc_q.size());
    else begin
      passed++;
      ea = exp_acc_q.pop_front();
      void'(exp_bit_q.pop_front());
      total++; if (obs_acc_q[0] !== ea) $display("[TB] FAIL mid_fresh_acc: got %h expected %h", obs_acc_q[0], ea); else passed++;
      total++; if (obs_bit_q[0] !== 1'b0) $display("[TB] FAIL mid_fresh_bit: got %b expected 0", obs_bit_q[0]); else passed++;
    end
    obs_acc_q.delete(); obs_bit_q.delete(); obs_busy_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_start_held();
    int s1, s2, guard;
    logic [31:0] ea;
    logic eb;
    for (int i = 0; i < NSEG; i++) segs[i] = 32'h0;
    segs[0] = 32'h7FFF_0000;
    segs[2] = 32'h7FFF_0000;
    send_symbol(0, 1'b1, s1);
    guard = 0;
    while (obs_acc_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
    total++;
    if (obs_acc_q.size() == 0) $display("[TB] FAIL held_done1: got no done expected one pulse");
    else begin
      passed++;
      ea = exp_acc_q.pop_front();
      eb = exp_bit_q.pop_front();
      total++; if (obs_acc_q[0] !== 32'hFFFE_0000 || obs_acc_q[0] !== ea) $display("[TB] FAIL held_wrap_acc: got %h expected fffe0000", obs_acc_q[0]); else passed++;
      total++; if (obs_bit_q[0] !== eb || obs_bit_q[0] !== 1'b0) $display("[TB] FAIL held_wrap_bit: got %b expected 0", obs_bit_q[0]); else passed++;
      total++; if (obs_busy_q[0] !== 1'b0) $display("[TB] FAIL held_idle_between: busy got %b expected 0", obs_busy_q[0]); else passed++;
      void'(obs_acc_q.pop_front()); void'(obs_bit_q.pop_front());
      void'(obs_busy_q.pop_front()); void'(obs_cyc_q.pop_front());
    end
    for (int i = 0; i < NSEG; i++) segs[i] = (i % 2 == 0) ? 32'h0003_8000 : 32'h0001_0000;
    send_symbol(0, 1'b1, s2);
    start = 1'b0;
    guard = 0;
    while (obs_acc_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
    repeat (6) @(negedge clk);
    total++;
    if (obs_acc_q.size() != 1) $display("[TB] FAIL held_count2: got %0d done expected 1", obs_acc_q.size());
    else begin
      passed++;
      ea = exp_acc_q.pop_front();
      eb = exp_bit_q.pop_front();
      total++; if (obs_acc_q[0] !== ea) $display("[TB] FAIL held_acc2: got %h expected %h", obs_acc_q[0], ea); else passed++;
      total++; if (obs_bit_q[0] !== eb) $display("[TB] FAIL held_bit2: got %b expected %b", obs_bit_q[0], eb); else passed++;
      total++; if (obs_cyc_q[0] - s2 !== 12) $display("[TB] FAIL held_latency2: got %0d expected 12", obs_cyc_q[0] - s2); else passed++;
    end
    total++; if (busy !== 1'b0) $display("[TB] FAIL held_final_idle: busy got %b expected 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternating(0, 12);
    test_alternating(3, 15);
    test_reset_midway();
    test_start_held();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000 expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
